parity_frame_checker: RTL and testbench
=======================================

// Module: parity_frame_checker
// PURPOSE
// - Serial frame receiver and parity checker: shifts in NDATA data bits plus one parity bit from a bit stream.
// - Tracks running parity per frame and flags parity errors in EVEN or ODD mode.
// - Sits between the board switches (SWI-driven bit source) and the LED/LCD display outputs.
// - Counts error frames for display.
// PARAMETERS
// - NDATA     8  data bits per frame (2..32)
// - NERRCNT   8  width of error counter
// - ODD_DFLT  0  parity mode after reset (0=EVEN, 1=ODD)
// PORTS
// - clk_2       in   1        clock
// - reset       in   1        synchronous, active-high
// - start       in   1        begin a frame (sampled in IDLE/DONE only)
// - bit_valid   in   1        in_bit is sampled on this cycle
// - in_bit      in   1        serial data, LSB first, then parity bit
// - odd_sel     in   1        mode request; latched only at frame start
// - busy        out  1        1 in DATA or PARB
// - even_now    out  1        1 when count of 1s received so far in frame is even
// - frame_done  out  1        one-cycle pulse, frame complete
// - parity_err  out  1        valid with frame_done; held until next frame_done
// - data_out    out  NDATA    last completed frame data; updated with frame_done
// - err_count   out  NERRCNT  frames with parity error, saturating
// BEHAVIOUR
// - Reset, synchronous, active-high; clock clk_2.
// - Reset values: state=IDLE, busy=0, even_now=1, frame_done=0, parity_err=0, data_out=0, err_count=0, mode=ODD_DFLT.
// - States: IDLE, DATA, PARB, DONE.
// - IDLE --start--> DATA.
//   - Clears shift reg, bit_idx=0, even_now=1; latches odd_sel into mode.
// - DATA:
//   - Each bit_valid cycle: shift in_bit into position bit_idx.
//   - even_now toggles when in_bit=1; bit_idx++.
//   - After bit NDATA-1 -> PARB.
//   - Cycles without bit_valid hold all state.
// - PARB: on bit_valid, sample parity bit p -> DONE.
//   - Total ones over data+p: error if odd in EVEN mode, even in ODD mode.
// - DONE (exactly 1 cycle):
//   - frame_done=1; data_out and parity_err registered.
//   - err_count += parity_err, saturating at all-ones.
//   - If start=1: go straight to DATA (back-to-back frames, zero gap). Else -> IDLE.
// - start in DATA/PARB is ignored; odd_sel changes mid-frame are ignored.
// - bit_valid in IDLE/DONE is ignored; even_now unchanged.
// - Reset mid-frame: partial frame discarded, no frame_done; err_count cleared.
// - Latency: frame_done asserts 1 cycle after the clock edge that samples the parity bit.
// - Outputs are registered except busy, which is decoded from state.
// STRUCTURE
// - Package parity_pkg:
//   - typedef enum logic [1:0] {IDLE, DATA, PARB, DONE} pfc_state_t.
//   - typedef enum logic {EVEN, ODD} parity_mode_t.
// - Sub-module parity_accum (NDATA):
//   - Inputs: clr, en, in_bit.
//   - Outputs: shift reg, bit_idx, even_now, last_bit.
//   - Generalised PAR/IMPAR toggle.
// - Top-level FSM, mode latch, output registers and counter stay in parity_frame_checker.
// TESTING
// - Reset with NDATA=8, EVEN: send start and bits 0xA5 LSB-first, then p=0.
//   - Expect frame_done, data_out=0xA5, parity_err=0, err_count=0.
// - EVEN mode, 0x07, p=0 -> parity_err=1, err_count=1.
//   - Same frame with p=1 -> parity_err=0, err_count stays 1.
// - odd_sel=1 at start, 0x00, p=1 -> no error.
//   - Toggle odd_sel mid-frame: result unchanged.
// - bit_valid gaps: 3 idle cycles between every bit of 0x3C -> same result as gapless; even_now holds during gaps.
// - start held during DONE: two back-to-back frames 0x01/p=1 and 0xFF/p=0.
//   - Expect two frame_done pulses 9 valid bits apart, no IDLE cycle between frames.
// - Reset after 4 bits -> no frame_done, busy=0, even_now=1.
//   - Force 2^NERRCNT+3 bad frames -> err_count saturates at 0xFF.

Source files
------------

// File: rtl/parity_frame_checker_pkg.sv
// Shared types for the serial parity frame checker: FSM states, parity modes
// and the frame error rule.
package parity_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARB, DONE} pfc_state_t;
  typedef enum logic {EVEN, ODD} parity_mode_t;

  // data_even is the parity of the data bits alone; p then completes the frame
  function automatic logic frame_error(input logic data_even, input logic p,
                                       input parity_mode_t mode);
    logic total_odd;
    total_odd = ~data_even ^ p;
    return (mode == ODD) ? ~total_odd : total_odd;
  endfunction

endpackage

// File: rtl/parity_frame_checker_if.sv
// Bit-source / display-side signal bundle of the parity frame checker.
interface parity_frame_checker_if #(
  parameter int NDATA   = 8,
  parameter int NERRCNT = 8
);
  logic               start;
  logic               bit_valid;
  logic               in_bit;
  logic               odd_sel;
  logic               busy;
  logic               even_now;
  logic               frame_done;
  logic               parity_err;
  logic [NDATA-1:0]   data_out;
  logic [NERRCNT-1:0] err_count;

  modport master (
    output start, bit_valid, in_bit, odd_sel,
    input  busy, even_now, frame_done, parity_err, data_out, err_count
  );

  modport slave (
    input  start, bit_valid, in_bit, odd_sel,
    output busy, even_now, frame_done, parity_err, data_out, err_count
  );
endinterface

// File: rtl/parity_frame_checker_accum.sv
// Data-bit accumulator: places each accepted bit at its LSB-first position and
// keeps a running even/odd toggle of the ones seen in the current frame.
module parity_accum #(
  parameter  int NDATA = 8,
  localparam int IDXW  = (NDATA > 1) ? $clog2(NDATA) : 1
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             in_bit,
  output logic [NDATA-1:0] shift_reg,
  output logic [IDXW-1:0]  bit_idx,
  output logic             even_now,
  output logic             last_bit
);

  assign last_bit = en && (bit_idx == IDXW'(NDATA - 1));

  always_ff @(posedge clk_2) begin
    if (reset || clr) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      even_now  <= 1'b1;
    end else if (en) begin
      shift_reg[bit_idx] <= in_bit;
      bit_idx            <= bit_idx + IDXW'(1);
      if (in_bit)
        even_now <= ~even_now;
    end
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: NDATA data bits LSB first plus one parity bit, with
// EVEN/ODD checking, registered results and a saturating error-frame counter.
module parity_frame_checker #(
  parameter int NDATA    = 8,
  parameter int NERRCNT  = 8,
  parameter int ODD_DFLT = 0
) (
  input  logic                   clk_2,
  input  logic                   reset,
  parity_frame_checker_if.slave  bus
);
  import parity_pkg::*;

  localparam int IDXW = (NDATA > 1) ? $clog2(NDATA) : 1;

  pfc_state_t       state, next_state;
  parity_mode_t     mode;
  logic [NDATA-1:0] shift_reg;
  logic [IDXW-1:0]  bit_idx;
  logic             data_even;
  logic             last_bit;
  logic             frame_start;
  logic             acc_en;
  logic             take_parity;
  logic             bad_frame;

  // start is honoured only between frames, which also allows zero-gap chaining out of DONE
  assign frame_start = bus.start && ((state == IDLE) || (state == DONE));
  assign acc_en      = (state == DATA) && bus.bit_valid;
  assign take_parity = (state == PARB) && bus.bit_valid;
  assign bad_frame   = frame_error(data_even, bus.in_bit, mode);

  parity_accum #(.NDATA(NDATA)) u_accum (
    .clk_2     (clk_2),
    .reset     (reset),
    .clr       (frame_start),
    .en        (acc_en),
    .in_bit    (bus.in_bit),
    .shift_reg (shift_reg),
    .bit_idx   (bit_idx),
    .even_now  (data_even),
    .last_bit  (last_bit)
  );

  always_ff @(posedge clk_2) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start) next_state = DATA;
      DATA: if (last_bit) next_state = PARB;
      PARB: if (bus.bit_valid) next_state = DONE;
      DONE: next_state = bus.start ? DATA : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Results are registered on the parity-sampling edge so they appear during DONE
  always_ff @(posedge clk_2) begin
    if (reset) begin
      mode           <= (ODD_DFLT != 0) ? ODD : EVEN;
      bus.frame_done <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.data_out   <= '0;
      bus.err_count  <= '0;
    end else begin
      bus.frame_done <= 1'b0;
      if (frame_start)
        mode <= bus.odd_sel ? ODD : EVEN;
      if (take_parity) begin
        bus.frame_done <= 1'b1;
        bus.parity_err <= bad_frame;
        bus.data_out   <= shift_reg;
        if (bad_frame && (bus.err_count != '1))
          bus.err_count <= bus.err_count + NERRCNT'(1);
      end
    end
  end

  assign bus.busy     = (state == DATA) || (state == PARB);
  assign bus.even_now = data_even;

  logic unused_idx;
  assign unused_idx = ^bit_idx;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed-vector bench for parity_frame_checker (NDATA=8, NERRCNT=8, EVEN default).
module tb_parity_frame_checker;

  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  always #5 clk_2 = ~clk_2;

  parity_frame_checker_if #(.NDATA(8), .NERRCNT(8)) bus ();

  parity_frame_checker #(.NDATA(8), .NERRCNT(8), .ODD_DFLT(0)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one frame from a negedge; skip_start means the FSM is already in DATA
  task automatic applyStimulus(input logic [7:0] data, input logic p, input logic odd,
                               input int gap, input bit toggle_mid,
                               input bit chain_next, input bit skip_start);
    logic exp_even;
    logic exp_err;
    int   ones;
    exp_even = 1'b1;
    if (!skip_start) begin
      bus.start   = 1'b1;
      bus.odd_sel = odd;
      @(negedge clk_2);
      bus.start   = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      bus.bit_valid = 1'b1;
      bus.in_bit    = data[i];
      if (toggle_mid && i == 3) bus.odd_sel = ~odd;
      @(negedge clk_2);
      bus.bit_valid = 1'b0;
      bus.in_bit    = 1'b0;
      if (data[i]) exp_even = ~exp_even;
      for (int g = 0; g < gap; g++) begin
        checkOutput("gap_even_now", {31'd0, bus.even_now}, {31'd0, exp_even});
        @(negedge clk_2);
      end
    end
    bus.bit_valid = 1'b1;
    bus.in_bit    = p;
    @(negedge clk_2);
    bus.bit_valid = 1'b0;
    bus.in_bit    = 1'b0;
    bus.odd_sel   = 1'b0;
    ones    = $countones(data) + int'(p);
    exp_err = odd ? (ones % 2 == 0) : (ones % 2 == 1);
    if (exp_err && exp_cnt < 255) exp_cnt++;
    checkOutput("frame_done", {31'd0, bus.frame_done}, 32'd1);
    checkOutput("data_out", {24'd0, bus.data_out}, {24'd0, data});
    checkOutput("parity_err", {31'd0, bus.parity_err}, {31'd0, exp_err});
    checkOutput("err_count", {24'd0, bus.err_count}, exp_cnt);
    if (chain_next) begin
      bus.start = 1'b1;
      @(negedge clk_2);
      bus.start = 1'b0;
      checkOutput("chain_busy", {31'd0, bus.busy}, 32'd1);
      checkOutput("chain_done_low", {31'd0, bus.frame_done}, 32'd0);
    end else begin
      @(negedge clk_2);
      checkOutput("done_pulse_end", {31'd0, bus.frame_done}, 32'd0);
      checkOutput("idle_busy", {31'd0, bus.busy}, 32'd0);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.in_bit    = 1'b0;
    bus.odd_sel   = 1'b0;
    reset         = 1'b1;
    repeat (2) @(negedge clk_2);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_even_now", {31'd0, bus.even_now}, 32'd1);
    checkOutput("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    checkOutput("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);
    checkOutput("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    checkOutput("rst_err_count", {24'd0, bus.err_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk_2);

    applyStimulus(8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h07, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h07, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h3C, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Abandon a frame after four bits via reset
    bus.start = 1'b1;
    @(negedge clk_2);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.bit_valid = 1'b1;
      bus.in_bit    = 1'b1;
      @(negedge clk_2);
    end
    bus.bit_valid = 1'b0;
    bus.in_bit    = 1'b0;
    checkOutput("mid_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk_2);
    reset = 1'b0;
    exp_cnt = 0;
    checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort_even_now", {31'd0, bus.even_now}, 32'd1);
    checkOutput("abort_frame_done", {31'd0, bus.frame_done}, 32'd0);
    checkOutput("abort_err_count", {24'd0, bus.err_count}, 32'd0);
    @(negedge clk_2);
    checkOutput("abort_no_done", {31'd0, bus.frame_done}, 32'd0);

    for (int n = 0; n < 259; n++)
      applyStimulus(8'h07, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_err_count", {24'd0, bus.err_count}, 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
